// File: rtl/upstream_risk_engine.sv
// Multi-client pre-trade risk checker: per-client exposure/limit RAM, a read-check-write
// sequencer and a one-cycle verdict.
//
// state | meaning
// INIT  | post-reset sweep, clears one client slot per cycle
// IDLE  | ready for a request
// RD    | RAM read of the latched client in flight
// EX    | check evaluated, RAM written, verdict registered
// RSP   | verdict strobe on the response channel
module upstream_risk_engine #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_CLIENTS = 32,
  parameter int                CLIENT_W    = 5,
  parameter logic [DATA_W-1:0] DEFAULT_MAX = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_type,
  input  logic [CLIENT_W-1:0] client_id,
  input  logic [DATA_W-1:0]   amount,
  output logic                resp_valid,
  output logic                resp_accept,
  output logic [1:0]          resp_reason,
  output logic [CLIENT_W-1:0] resp_client,
  output logic [DATA_W-1:0]   exposure_out,
  output logic [DATA_W-1:0]   max_out
);

  typedef enum logic [2:0] {INIT, IDLE, RD, EX, RSP} state_t;

  localparam logic [CLIENT_W:0]   NUM_C = (CLIENT_W+1)'(NUM_CLIENTS);
  localparam logic [CLIENT_W-1:0] LAST  = CLIENT_W'(NUM_CLIENTS - 1);

  state_t state, state_nxt;

  logic [DATA_W-1:0]   exp_mem [NUM_CLIENTS];
  logic [DATA_W-1:0]   max_mem [NUM_CLIENTS];

  logic [CLIENT_W-1:0] sweep_cnt;
  logic [1:0]          req_type_q;
  logic [CLIENT_W-1:0] req_client_q;
  logic [DATA_W-1:0]   req_amount_q;
  logic [DATA_W-1:0]   rd_exp, rd_max;
  logic                acc_q;
  logic [1:0]          reason_q;

  logic                bad;
  logic [CLIENT_W-1:0] rd_addr;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   new_exp, new_max;
  logic                ex_accept, wr_ok;
  logic [1:0]          ex_reason;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_accept = 1'b0;
    resp_reason = 2'b00;
    case (state)
      INIT: if (sweep_cnt == LAST) state_nxt = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RD;
      end
      RD:   state_nxt = EX;
      EX:   state_nxt = RSP;
      RSP: begin
        resp_valid  = 1'b1;
        resp_accept = acc_q;
        resp_reason = reason_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Out-of-range clients never touch the RAM; their read is steered to slot 0 and discarded.
  assign bad     = (req_type_q == 2'b11) || ({1'b0, req_client_q} >= NUM_C);
  assign rd_addr = bad ? '0 : req_client_q;
  assign sum     = {1'b0, rd_exp} + {1'b0, req_amount_q};

  always_comb begin
    new_exp   = rd_exp;
    new_max   = rd_max;
    ex_accept = 1'b1;
    ex_reason = 2'b00;
    wr_ok     = 1'b0;
    if (bad) begin
      ex_accept = 1'b0;
      ex_reason = 2'b11;
    end else begin
      case (req_type_q)
        2'b00: begin
          if (sum[DATA_W]) begin
            ex_accept = 1'b0;
            ex_reason = 2'b10;
          end else if (sum[DATA_W-1:0] > rd_max) begin
            ex_accept = 1'b0;
            ex_reason = 2'b01;
          end else begin
            new_exp = sum[DATA_W-1:0];
            wr_ok   = 1'b1;
          end
        end
        2'b01: begin
          new_max = req_amount_q;
          wr_ok   = 1'b1;
        end
        2'b10: begin
          new_exp = (req_amount_q > rd_exp) ? '0 : rd_exp - req_amount_q;
          wr_ok   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_cnt    <= '0;
      req_type_q   <= '0;
      req_client_q <= '0;
      req_amount_q <= '0;
      rd_exp       <= '0;
      rd_max       <= '0;
      acc_q        <= 1'b0;
      reason_q     <= 2'b00;
      resp_client  <= '0;
      exposure_out <= '0;
      max_out      <= '0;
    end else begin
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
      if (state == IDLE && req_valid) begin
        req_type_q   <= req_type;
        req_client_q <= client_id;
        req_amount_q <= amount;
      end
      if (state == RD) begin
        rd_exp <= exp_mem[rd_addr];
        rd_max <= max_mem[rd_addr];
      end
      if (state == EX) begin
        acc_q        <= ex_accept;
        reason_q     <= ex_reason;
        resp_client  <= req_client_q;
        exposure_out <= bad ? '0 : new_exp;
        max_out      <= bad ? '0 : new_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        exp_mem[sweep_cnt] <= '0;
        max_mem[sweep_cnt] <= DEFAULT_MAX;
      end else if (state == EX && wr_ok) begin
        exp_mem[req_client_q] <= new_exp;
        max_mem[req_client_q] <= new_max;
      end
    end
  end

endmodule

// File: tb/tb_upstream_risk_engine.sv
// Directed and random checks of upstream_risk_engine against a per-client arithmetic model.
module tb_upstream_risk_engine;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [4:0]  client_id;
  logic [31:0] amount;
  logic        resp_valid;
  logic        resp_accept;
  logic [1:0]  resp_reason;
  logic [4:0]  resp_client;
  logic [31:0] exposure_out;
  logic [31:0] max_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_exp [32];
  logic [31:0] m_max [32];

  upstream_risk_engine #(
    .DATA_W(32), .NUM_CLIENTS(N), .CLIENT_W(5), .DEFAULT_MAX(32'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .client_id(client_id), .amount(amount),
    .resp_valid(resp_valid), .resp_accept(resp_accept), .resp_reason(resp_reason),
    .resp_client(resp_client), .exposure_out(exposure_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_exp[i] = 32'd0;
      m_max[i] = 32'd0;
    end
  endtask

  task automatic model_step(input logic [1:0] t, input logic [4:0] id, input logic [31:0] amt,
                            output logic acc, output logic [1:0] rsn,
                            output logic [31:0] eexp, output logic [31:0] emax);
    longint unsigned s;
    acc = 1'b1; rsn = 2'd0;
    if (int'(id) >= N || t == 2'd3) begin
      acc = 1'b0; rsn = 2'd3; eexp = 32'd0; emax = 32'd0;
      return;
    end
    if (t == 2'd0) begin
      s = longint'(m_exp[id]) + longint'(amt);
      if (s > 64'hFFFF_FFFF)      begin acc = 1'b0; rsn = 2'd2; end
      else if (s > m_max[id])     begin acc = 1'b0; rsn = 2'd1; end
      else m_exp[id] = s[31:0];
    end else if (t == 2'd1) begin
      m_max[id] = amt;
    end else begin
      m_exp[id] = (amt >= m_exp[id]) ? 32'd0 : m_exp[id] - amt;
    end
    eexp = m_exp[id];
    emax = m_max[id];
  endtask

  // Issues one request from a negedge and checks the full response window.
  task automatic do_req(input logic [1:0] t, input logic [4:0] id, input logic [31:0] amt);
    logic eacc; logic [1:0] ersn; logic [31:0] eexp, emax;
    int w;
    model_step(t, id, amt, eacc, ersn, eexp, emax);
    req_valid = 1'b1; req_type = t; client_id = id; amount = amt;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("handshake_wait", 64'(w < 50), 64'd1);
    if (w >= 50) begin req_valid = 1'b0; return; end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("rv_at_T", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("rv_at_T1", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("rv_at_T2", 64'(resp_valid), 64'd1);
    chk("accept", 64'(resp_accept), 64'(eacc));
    chk("reason", 64'(resp_reason), 64'(ersn));
    chk("resp_client", 64'(resp_client), 64'(id));
    chk("exposure_out", 64'(exposure_out), 64'(eexp));
    chk("max_out", 64'(max_out), 64'(emax));
    @(negedge clk);
    chk("rv_after", 64'(resp_valid), 64'd0);
    chk("accept_idle", 64'(resp_accept), 64'd0);
    chk("reason_idle", 64'(resp_reason), 64'd0);
    chk("ready_again", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int cnt, k, nr, rv_seen;
    int hs [4];
    logic [4:0]  ids  [4];
    logic [31:0] amts [4];
    logic [4:0]  got_cli [8];
    logic [31:0] got_max [8];
    logic [4:0]  exp_cli [4];
    logic [31:0] exp_max [4];
    logic eacc; logic [1:0] ersn; logic [31:0] eexp, emax;
    logic [1:0] rt; logic [31:0] ra; int rr;

    rst_n = 1'b0; req_valid = 1'b0; req_type = 2'd0; client_id = '0; amount = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_exp", 64'(exposure_out), 64'd0);
    chk("rst_max", 64'(max_out), 64'd0);
    chk("rst_client", 64'(resp_client), 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("sweep_len", 64'(cnt), 64'(N));

    do_req(2'd0, 5'd3, 32'd1);

    do_req(2'd1, 5'd5, 32'd1000);
    do_req(2'd0, 5'd5, 32'd600);
    do_req(2'd0, 5'd5, 32'd500);
    do_req(2'd2, 5'd5, 32'd200);
    do_req(2'd0, 5'd5, 32'd500);

    do_req(2'd1, 5'd6, 32'hFFFF_FFFF);
    do_req(2'd0, 5'd6, 32'hFFFF_FFF0);
    do_req(2'd0, 5'd6, 32'h20);
    do_req(2'd2, 5'd6, 32'hFFFF_FFFF);

    do_req(2'd0, 5'd25, 32'd5);
    do_req(2'd1, 5'd20, 32'd9);
    do_req(2'd3, 5'd5, 32'd7);
    do_req(2'd0, 5'd5, 32'd0);
    do_req(2'd0, 5'd6, 32'd0);
    do_req(2'd1, 5'd19, 32'd77);

    // Continuous req_valid across four queued requests.
    ids[0] = 5'd1;   ids[1] = 5'd2;   ids[2] = 5'd3;   ids[3] = 5'd4;
    amts[0] = 32'd11; amts[1] = 32'd22; amts[2] = 32'd33; amts[3] = 32'd44;
    k = 0; nr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 && nr < 8) begin
        got_cli[nr] = resp_client; got_max[nr] = max_out; nr++;
      end
      if (k < 4) begin
        req_valid = 1'b1; req_type = 2'd1; client_id = ids[k]; amount = amts[k];
        if (req_ready === 1'b1) begin
          hs[k] = c;
          model_step(2'd1, ids[k], amts[k], eacc, ersn, eexp, emax);
          exp_cli[k] = ids[k]; exp_max[k] = emax;
          k++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    chk("hs_count", 64'(k), 64'd4);
    chk("resp_count", 64'(nr), 64'd4);
    for (int i = 1; i < 4; i++)
      if (i < k) chk($sformatf("hs_gap%0d", i), 64'(hs[i] - hs[i-1]), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < nr && i < k) begin
        chk($sformatf("order_client%0d", i), 64'(got_cli[i]), 64'(exp_cli[i]));
        chk($sformatf("order_max%0d", i), 64'(got_max[i]), 64'(exp_max[i]));
      end

    for (int i = 0; i < 20; i++) do_req(2'd1, 5'(i), $urandom_range(500, 5000));
    for (int i = 0; i < 70; i++) begin
      rr = $urandom_range(0, 9);
      rt = (rr < 5) ? 2'd0 : (rr < 7) ? 2'd1 : (rr < 9) ? 2'd2 : 2'd3;
      ra = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3000));
      do_req(rt, 5'($urandom_range(0, 22)), ra);
    end

    do_req(2'd1, 5'd7, 32'd100);
    do_req(2'd0, 5'd7, 32'd50);
    req_valid = 1'b1; req_type = 2'd0; client_id = 5'd7; amount = 32'd10;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("mid_hs_wait", 64'(cnt < 50), 64'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rv", 64'(resp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_exp", 64'(exposure_out), 64'd0);
    chk("mid_rst_max", 64'(max_out), 64'd0);
    chk("mid_rst_client", 64'(resp_client), 64'd0);
    rst_n = 1'b1;
    model_reset();
    cnt = 0; rv_seen = 0;
    while (req_ready !== 1'b1 && cnt < 200) begin
      @(negedge clk); cnt++;
      if (resp_valid !== 1'b0) rv_seen++;
    end
    chk("sweep_len2", 64'(cnt), 64'(N));
    chk("no_resp_after_rst", 64'(rv_seen), 64'd0);
    do_req(2'd0, 5'd7, 32'd0);
    do_req(2'd0, 5'd5, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
